// File: rtl/usb_rst_pkg.sv
// Shared types and helpers for the USB1 reset sequencer.
package usb_rst_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PWRUP   = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    SRST    = 3'd4
  } rst_state_e;

  // Cycles spanned by a delay in microseconds at the given clock frequency.
  function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned freq_hz);
    return us * (freq_hz / 32'd1000000);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/usb_dly_cnt.sv
// Loadable down-counter shared by the power-up, stage-spacing and soft-reset hold timing.
module usb_dly_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rstl_i,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         enable,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rstl_i) begin
    if (!rstl_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // A delay of N cycles is loaded as N-1; done marks the last cycle of the delay.
  assign done = enable && (cnt_q == '0);

endmodule

// File: rtl/usb_rst_seq.sv
// Staged reset release sequencer with serialised soft-reset requests for the USB1 core.
module usb_rst_seq
  import usb_rst_pkg::*;
#(
  parameter int unsigned P_FREQUENCY     = 48000000,
  parameter int unsigned P_STAGES        = 3,
  parameter int unsigned P_REQ           = 2,
  parameter int unsigned P_PWRUP_DLY_US  = 50,
  parameter int unsigned P_STAGE_DLY_US  = 10,
  parameter int unsigned P_SRST_HOLD_CYC = 16
) (
  input  logic                clk_i,
  input  logic                rstl_i,
  input  logic                en_i,
  input  logic [P_REQ-1:0]    srst_req_i,
  output logic [P_REQ-1:0]    srst_ack_o,
  output logic [P_STAGES-1:0] rsth_o,
  output logic                ready_o,
  output logic [2:0]          state_o
);

  localparam int unsigned D_PWR   = us_to_cyc(P_PWRUP_DLY_US, P_FREQUENCY);
  localparam int unsigned D_STG   = us_to_cyc(P_STAGE_DLY_US, P_FREQUENCY);
  localparam int unsigned CNT_MAX = max3(D_PWR, D_STG, P_SRST_HOLD_CYC);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned STG_W   = $clog2(P_STAGES + 1);

  rst_state_e          state_q, state_d;
  logic [STG_W-1:0]    idx_q, idx_d;
  logic [P_REQ-1:0]    pend_q, pend_d;
  logic [P_REQ-1:0]    ack_d;
  logic [P_STAGES-1:0] rsth_d;
  logic                ready_d;
  logic                cnt_load, cnt_en, cnt_done;
  logic [CNT_W-1:0]    cnt_value;

  usb_dly_cnt #(.W(CNT_W)) u_dly_cnt (
    .clk_i  (clk_i),
    .rstl_i (rstl_i),
    .load   (cnt_load),
    .value  (cnt_value),
    .enable (cnt_en),
    .done   (cnt_done)
  );

  // Next-state, counter control and next output values.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    ack_d     = '0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_value = '0;

    if (!en_i) begin
      state_d = IDLE;
      idx_d   = '0;
      pend_d  = '0;
    end else begin
      if (state_q != IDLE) pend_d = pend_q | srst_req_i;

      unique case (state_q)
        IDLE: begin
          state_d   = PWRUP;
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(D_PWR - 1);
        end
        PWRUP: begin
          cnt_en = 1'b1;
          if (cnt_done) begin
            state_d   = RELEASE;
            idx_d     = STG_W'(1);
            cnt_load  = 1'b1;
            cnt_value = CNT_W'(D_STG - 1);
          end
        end
        RELEASE: begin
          cnt_en = 1'b1;
          // A request mid-release re-asserts every stage and restarts the hold.
          if (|srst_req_i) begin
            state_d   = SRST;
            idx_d     = '0;
            cnt_load  = 1'b1;
            cnt_value = CNT_W'(P_SRST_HOLD_CYC - 1);
          end else if (cnt_done) begin
            if (idx_q == STG_W'(P_STAGES)) begin
              state_d = RUN;
              ack_d   = pend_q;
              pend_d  = '0;
            end else begin
              idx_d     = idx_q + STG_W'(1);
              cnt_load  = 1'b1;
              cnt_value = CNT_W'(D_STG - 1);
            end
          end
        end
        RUN: begin
          if (|srst_req_i) begin
            state_d   = SRST;
            idx_d     = '0;
            cnt_load  = 1'b1;
            cnt_value = CNT_W'(P_SRST_HOLD_CYC - 1);
          end
        end
        SRST: begin
          cnt_en = 1'b1;
          if (cnt_done) begin
            state_d   = RELEASE;
            idx_d     = STG_W'(1);
            cnt_load  = 1'b1;
            cnt_value = CNT_W'(D_STG - 1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          pend_d  = '0;
        end
      endcase
    end

    // Stage k is released once idx counts past it; everything is released in RUN.
    rsth_d = '1;
    for (int unsigned k = 0; k < P_STAGES; k++) begin
      if ((state_d == RUN) || ((state_d == RELEASE) && (STG_W'(k) < idx_d))) rsth_d[k] = 1'b0;
    end
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk_i or negedge rstl_i) begin
    if (!rstl_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pend_q     <= '0;
      srst_ack_o <= '0;
      rsth_o     <= '1;
      ready_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      srst_ack_o <= ack_d;
      rsth_o     <= rsth_d;
      ready_o    <= ready_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_usb_rst_seq.sv
// Directed table-driven bench for usb_rst_seq with D_PWR=8, D_STG=4, hold=4.
module tb_usb_rst_seq;

  logic       clk;
  logic       rstl;
  logic       en;
  logic [1:0] req;
  logic [1:0] ack;
  logic [2:0] rsth;
  logic       ready;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  usb_rst_seq #(
    .P_FREQUENCY     (4000000),
    .P_STAGES        (3),
    .P_REQ           (2),
    .P_PWRUP_DLY_US  (2),
    .P_STAGE_DLY_US  (1),
    .P_SRST_HOLD_CYC (4)
  ) dut (
    .clk_i      (clk),
    .rstl_i     (rstl),
    .en_i       (en),
    .srst_req_i (req),
    .srst_ack_o (ack),
    .rsth_o     (rsth),
    .ready_o    (ready),
    .state_o    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record: drive en/req, advance adv edges (req only on the first), then compare.
  typedef struct packed {
    logic        en;
    logic [1:0]  req;
    int unsigned adv;
    logic [2:0]  rsth;
    logic        ready;
    logic [1:0]  ack;
    logic [2:0]  state;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic [1:0] r, input int unsigned a,
                     input logic [2:0] rs, input logic rd, input logic [1:0] ak,
                     input logic [2:0] st);
    vec_t v;
    v.en = e; v.req = r; v.adv = a; v.rsth = rs; v.ready = rd; v.ack = ak; v.state = st;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] got,
                     input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %b, expected %b at %0t", name, idx, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input int idx, input logic [2:0] rs,
                         input logic rd, input logic [1:0] ak, input logic [2:0] st);
    chk({name, ".rsth"}, idx, 8'(rsth), 8'(rs));
    chk({name, ".ready"}, idx, 8'(ready), 8'(rd));
    chk({name, ".ack"}, idx, 8'(ack), 8'(ak));
    chk({name, ".state"}, idx, 8'(state), 8'(st));
  endtask

  initial begin
    // Power-up from cycle 0 = first PWRUP cycle
    add(1, 2'b00, 1,  3'b111, 0, 2'b00, 3'd1);
    add(1, 2'b00, 7,  3'b111, 0, 2'b00, 3'd1);
    add(1, 2'b00, 1,  3'b110, 0, 2'b00, 3'd2);
    add(1, 2'b00, 3,  3'b110, 0, 2'b00, 3'd2);
    add(1, 2'b00, 1,  3'b100, 0, 2'b00, 3'd2);
    add(1, 2'b00, 4,  3'b000, 0, 2'b00, 3'd2);
    add(1, 2'b00, 3,  3'b000, 0, 2'b00, 3'd2);
    add(1, 2'b00, 1,  3'b000, 1, 2'b00, 3'd3);
    add(1, 2'b00, 1,  3'b000, 1, 2'b00, 3'd3);
    // Single request at t
    add(1, 2'b01, 1,  3'b111, 0, 2'b00, 3'd4);
    add(1, 2'b00, 3,  3'b111, 0, 2'b00, 3'd4);
    add(1, 2'b00, 1,  3'b110, 0, 2'b00, 3'd2);
    add(1, 2'b00, 4,  3'b100, 0, 2'b00, 3'd2);
    add(1, 2'b00, 4,  3'b000, 0, 2'b00, 3'd2);
    add(1, 2'b00, 3,  3'b000, 0, 2'b00, 3'd2);
    add(1, 2'b00, 1,  3'b000, 1, 2'b01, 3'd3);
    add(1, 2'b00, 1,  3'b000, 1, 2'b00, 3'd3);
    // Merged: second requester arrives during the hold, hold not restarted
    add(1, 2'b01, 2,  3'b111, 0, 2'b00, 3'd4);
    add(1, 2'b10, 2,  3'b111, 0, 2'b00, 3'd4);
    add(1, 2'b00, 1,  3'b110, 0, 2'b00, 3'd2);
    add(1, 2'b00, 11, 3'b000, 0, 2'b00, 3'd2);
    add(1, 2'b00, 1,  3'b000, 1, 2'b11, 3'd3);
    add(1, 2'b00, 1,  3'b000, 1, 2'b00, 3'd3);
    // Request during RELEASE restarts the hold; ack at t+23
    add(1, 2'b01, 6,  3'b110, 0, 2'b00, 3'd2);
    add(1, 2'b10, 1,  3'b111, 0, 2'b00, 3'd4);
    add(1, 2'b00, 4,  3'b110, 0, 2'b00, 3'd2);
    add(1, 2'b00, 11, 3'b000, 0, 2'b00, 3'd2);
    add(1, 2'b00, 1,  3'b000, 1, 2'b11, 3'd3);
    add(1, 2'b00, 1,  3'b000, 1, 2'b00, 3'd3);
    // Request on the RUN-entry cycle is left for the next ack
    add(1, 2'b01, 17, 3'b000, 1, 2'b01, 3'd3);
    add(1, 2'b10, 1,  3'b111, 0, 2'b00, 3'd4);
    add(1, 2'b00, 16, 3'b000, 1, 2'b10, 3'd3);
    add(1, 2'b00, 1,  3'b000, 1, 2'b00, 3'd3);
    // Abort mid-RELEASE with a request pending, then full power-up again with no ack
    add(1, 2'b01, 6,  3'b110, 0, 2'b00, 3'd2);
    add(0, 2'b00, 1,  3'b111, 0, 2'b00, 3'd0);
    add(0, 2'b00, 3,  3'b111, 0, 2'b00, 3'd0);
    add(1, 2'b00, 1,  3'b111, 0, 2'b00, 3'd1);
    add(1, 2'b00, 7,  3'b111, 0, 2'b00, 3'd1);
    add(1, 2'b00, 1,  3'b110, 0, 2'b00, 3'd2);
    add(1, 2'b00, 12, 3'b000, 1, 2'b00, 3'd3);

    rstl = 1'b0;
    en   = 1'b0;
    req  = 2'b00;
    repeat (2) tick();
    chk_all("reset", 0, 3'b111, 1'b0, 2'b00, 3'd0);

    en   = 1'b1;
    rstl = 1'b1;
    foreach (vecs[i]) begin
      en  = vecs[i].en;
      req = vecs[i].req;
      tick();
      req = 2'b00;
      for (int unsigned c = 1; c < vecs[i].adv; c++) tick();
      chk_all("vec", i, vecs[i].rsth, vecs[i].ready, vecs[i].ack, vecs[i].state);
    end

    // Asynchronous reset in the middle of a soft-reset hold
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    chk("async.pre_state", 0, 8'(state), 8'd4);
    #2;
    rstl = 1'b0;
    #1;
    chk_all("async", 0, 3'b111, 1'b0, 2'b00, 3'd0);
    repeat (2) tick();
    chk_all("async_hold", 0, 3'b111, 1'b0, 2'b00, 3'd0);
    rstl = 1'b1;
    tick();
    chk_all("async_restart", 0, 3'b111, 1'b0, 2'b00, 3'd1);
    repeat (8) tick();
    chk_all("async_restart", 1, 3'b110, 1'b0, 2'b00, 3'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_rst_seq.md
# usb_rst_seq

Synthesizable reset sequencer and soft-reset arbiter for the USB1 interface core. It owns the core's reset resource. After power-up it releases a chain of per-stage active-high resets in a fixed order with programmable spacing. It also serialises soft-reset requests from several requesters (USB bus-reset detector, register block, etc.), re-runs the release sequence, and acknowledges every requester it served. It sits between the board reset/clock input and all USB1 sub-blocks.

## Interface
- P_FREQUENCY, 48000000, clk_i frequency in Hz; must be an integer multiple of 1000000.
- P_STAGES, 3, number of staged resets (1..8).
- P_REQ, 2, number of soft-reset requesters (1..8).
- P_PWRUP_DLY_US, 50, power-up delay before the first stage release, in µs (≥1).
- P_STAGE_DLY_US, 10, spacing between consecutive stage releases, in µs (≥1).
- P_SRST_HOLD_CYC, 16, cycles all resets are held during a soft reset (≥1).

Ports:
- clk_i, in, 1: single clock.
- rstl_i, in, 1: reset, asynchronous, active-low.
- en_i, in, 1: sequencer enable; low forces the fully reset state.
- srst_req_i, in, P_REQ: one-cycle soft-reset request pulses, one bit per requester.
- srst_ack_o, out, P_REQ: one-cycle acknowledge pulses, one bit per requester.
- rsth_o, out, P_STAGES: active-high stage resets; bit 0 is released first.
- ready_o, out, 1: high only in RUN.
- state_o, out, 3: current state encoding, for debug.

## Operation
- Derived constants:
  - CPU = P_FREQUENCY/1000000.
  - D_PWR = P_PWRUP_DLY_US·CPU cycles.
  - D_STG = P_STAGE_DLY_US·CPU cycles.
  - The counter is sized $clog2(max(D_PWR, D_STG, P_SRST_HOLD_CYC)+1) bits.
- States:
  - IDLE: all rsth_o = 1. Go to PWRUP on the first clock with en_i = 1.
  - PWRUP: count D_PWR cycles, then go to RELEASE.
  - RELEASE: release stages 0..P_STAGES-1 one every D_STG cycles. D_STG cycles after the last release, go to RUN.
  - RUN: all rsth_o = 0 and ready_o = 1. Any srst_req_i bit goes to SRST.
  - SRST: all rsth_o = 1 and the counter is reloaded. After P_SRST_HOLD_CYC cycles go to RELEASE. PWRUP is never re-entered.
- Pending mask: a P_REQ-bit register. Every srst_req_i bit ORs into it in any state except IDLE.
- Acknowledge: on the cycle RUN is entered, srst_ack_o = pending for exactly one cycle, and pending is cleared in the same cycle.
- Request arriving in SRST: merged into pending; the hold counter is not restarted.
- Request arriving in RELEASE: go to SRST next cycle. All stages are re-asserted and the hold restarts.
- Request arriving on the same cycle RUN is entered: it is not part of that ack. It stays pending, starts a new SRST, and is acked at the next RUN entry.
- Simultaneous requests from several requesters: one SRST sequence; all of them are acked together.
- en_i low in any state: IDLE on the next clock. All rsth_o = 1, pending cleared, no ack issued.
- rstl_i low at any time, including mid-sequence: immediate IDLE with all outputs at their reset values.

## Timing
- Reset values:
  - rsth_o = all ones.
  - ready_o = 0.
  - srst_ack_o = 0.
  - state_o = IDLE.
  - pending = 0.
  - counter = 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Power-up sequence, with cycle 0 = first PWRUP cycle:
  - rsth_o[k] falls at cycle D_PWR + k·D_STG.
  - ready_o rises at cycle D_PWR + P_STAGES·D_STG.
- Soft reset, with a request at cycle t in RUN:
  - rsth_o all high and ready_o low from t+1.
  - rsth_o[k] falls at t+1+P_SRST_HOLD_CYC + k·D_STG.
  - ready_o and srst_ack_o rise at t+1+P_SRST_HOLD_CYC + P_STAGES·D_STG.

## Structure
- Package usb_rst_pkg holds:
  - the state enum (IDLE, PWRUP, RELEASE, RUN, SRST);
  - a function computing cycles from µs and frequency.
- Sub-module usb_dly_cnt: a loadable down-counter.
  - Inputs: load, value, enable.
  - Output: done, which goes high on the cycle the count reaches zero.
  - It is shared by the PWRUP, RELEASE and SRST timing.
- A stage index register (width $clog2(P_STAGES+1)) lives in the top module.

## Test plan
All scenarios use P_FREQUENCY=4000000, P_PWRUP_DLY_US=2, P_STAGE_DLY_US=1, P_STAGES=3, P_SRST_HOLD_CYC=4, P_REQ=2. This gives D_PWR=8 and D_STG=4.
- Power-up: release rstl_i with en_i=1 → rsth_o[0], [1], [2] fall at PWRUP cycles 8, 12, 16; ready_o rises at cycle 20.
- Single request: srst_req_i=01 at cycle t in RUN → rsth_o=111 at t+1; stages fall at t+5, t+9, t+13; srst_ack_o=01 for one cycle at t+17.
- Merged requests: srst_req_i=01 at t, then 10 at t+2 (during SRST) → one sequence; srst_ack_o=11 at t+17.
- Request during RELEASE: request at t, then a second request at t+6 → rsth_o returns to 111 at t+7; ack at t+7+4+12 = t+23.
- Abort: drive en_i=0 during RELEASE, with a request pending → IDLE next cycle, rsth_o=111, no ack ever; en_i=1 restarts the full power-up timing.
- Async reset: pulse rstl_i low mid-SRST without a clock edge → outputs return to their reset values immediately.
